// File: rtl/gpio_f2m_debounce.sv
// gpio_f2m_debounce
// Conditions eight raw fabric inputs into clean levels for the MSS GPIO
// fabric-to-MSS inputs. Each channel gets a two-flop synchronizer and a
// counter that must see the new level for DEBOUNCE_CYCLES consecutive clocks
// before the output follows.
//
// Optional feature macro: GPIO_F2M_EVENT_EN
//   defined   -> sticky CHANGED flags (cleared by CHANGE_CLR, set wins) and a
//                registered one-cycle EVENT pulse are built.
//   undefined -> CHANGED = 8'h00, EVENT = 0, CHANGE_CLR is ignored.
module gpio_f2m_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic       FAB_CCC_GL0,
  input  logic       FAB_RESET_N,
  input  logic [7:0] PAD_IN,
  input  logic       CHANGE_CLR,
  output logic       GPIO_0_F2M,
  output logic       GPIO_1_F2M,
  output logic       GPIO_2_F2M,
  output logic       GPIO_3_F2M,
  output logic       GPIO_4_F2M,
  output logic       GPIO_5_F2M,
  output logic       GPIO_6_F2M,
  output logic       GPIO_7_F2M,
  output logic [7:0] CHANGED,
  output logic       EVENT
);

  // Counter width is derived from the qualification length.
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);

  // Terminal count: the clock on which the counter sits here while the input
  // still differs is the clock on which the output follows.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [7:0]       sync1;
  logic [7:0]       sync2;
  logic [7:0]       stable;
  logic [CNT_W-1:0] cnt [8];
  logic [7:0]       differ;
  logic [7:0]       update;

  // Two-flop synchronizer per channel to tame the asynchronous pads.
  always_ff @(posedge FAB_CCC_GL0 or negedge FAB_RESET_N) begin
    if (!FAB_RESET_N) begin
      sync1 <= 8'h00;
      sync2 <= 8'h00;
    end else begin
      sync1 <= PAD_IN;
      sync2 <= sync1;
    end
  end

  // Per-channel decision: does the synchronized level disagree with the
  // output, and has it disagreed long enough to be accepted this clock.
  always_comb begin
    differ = 8'h00;
    update = 8'h00;
    for (int i = 0; i < 8; i++) begin
      differ[i] = (sync2[i] != stable[i]);
      update[i] = differ[i] && (cnt[i] == CNT_LAST);
    end
  end

  // Qualification counters: any agreement restarts the count, and the count
  // is cleared on acceptance so it never needs to wrap.
  always_ff @(posedge FAB_CCC_GL0 or negedge FAB_RESET_N) begin
    if (!FAB_RESET_N) begin
      for (int i = 0; i < 8; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (!differ[i] || update[i]) begin
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  // Debounced levels: a channel flips only on its accepted clock.
  always_ff @(posedge FAB_CCC_GL0 or negedge FAB_RESET_N) begin
    if (!FAB_RESET_N) begin
      stable <= 8'h00;
    end else begin
      stable <= stable ^ update;
    end
  end

  assign GPIO_0_F2M = stable[0];
  assign GPIO_1_F2M = stable[1];
  assign GPIO_2_F2M = stable[2];
  assign GPIO_3_F2M = stable[3];
  assign GPIO_4_F2M = stable[4];
  assign GPIO_5_F2M = stable[5];
  assign GPIO_6_F2M = stable[6];
  assign GPIO_7_F2M = stable[7];

`ifdef GPIO_F2M_EVENT_EN
  logic [7:0] changed_q;
  logic       event_q;

  // Sticky change flags for firmware: a clear wipes them, but a channel
  // updating on the same clock sets its flag anyway so no change is lost.
  always_ff @(posedge FAB_CCC_GL0 or negedge FAB_RESET_N) begin
    if (!FAB_RESET_N) begin
      changed_q <= 8'h00;
    end else begin
      changed_q <= (changed_q & {8{~CHANGE_CLR}}) | update;
    end
  end

  // One-cycle pulse lined up with the new GPIO level when any channel moves.
  always_ff @(posedge FAB_CCC_GL0 or negedge FAB_RESET_N) begin
    if (!FAB_RESET_N) begin
      event_q <= 1'b0;
    end else begin
      event_q <= |update;
    end
  end

  assign CHANGED = changed_q;
  assign EVENT   = event_q;
`else
  logic unused_change_clr;

  assign unused_change_clr = CHANGE_CLR;
  assign CHANGED           = 8'h00;
  assign EVENT             = 1'b0;
`endif

endmodule

// File: tb/tb_gpio_f2m_debounce.sv
// Self-checking bench for gpio_f2m_debounce with DEBOUNCE_CYCLES = 4.
// Expected CHANGED/EVENT values collapse to zero when GPIO_F2M_EVENT_EN is
// not defined for the build.
module tb_gpio_f2m_debounce;

  logic       clk;
  logic       rst_n;
  logic [7:0] pad_in;
  logic       change_clr;
  logic       gpio0, gpio1, gpio2, gpio3, gpio4, gpio5, gpio6, gpio7;
  logic [7:0] changed;
  logic       event_out;
  logic [7:0] gpio;

  int total;
  int bad;

  typedef struct {
    logic [7:0] pad;
    logic       clr;
    logic [7:0] gpio;
    logic [7:0] changed;
    logic       ev;
  } vec_t;

  vec_t vecs[$];

  assign gpio = {gpio7, gpio6, gpio5, gpio4, gpio3, gpio2, gpio1, gpio0};

  gpio_f2m_debounce #(
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .FAB_CCC_GL0(clk),
    .FAB_RESET_N(rst_n),
    .PAD_IN(pad_in),
    .CHANGE_CLR(change_clr),
    .GPIO_0_F2M(gpio0),
    .GPIO_1_F2M(gpio1),
    .GPIO_2_F2M(gpio2),
    .GPIO_3_F2M(gpio3),
    .GPIO_4_F2M(gpio4),
    .GPIO_5_F2M(gpio5),
    .GPIO_6_F2M(gpio6),
    .GPIO_7_F2M(gpio7),
    .CHANGED(changed),
    .EVENT(event_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic void add_row(input logic [7:0] p, input logic c,
                                  input logic [7:0] g, input logic [7:0] ch,
                                  input logic e);
    vec_t v;
    v.pad     = p;
    v.clr     = c;
    v.gpio    = g;
    v.changed = ch;
    v.ev      = e;
    vecs.push_back(v);
  endfunction

  // Drive inputs at a falling edge and let exactly one rising edge pass.
  task automatic applyStimulus(input logic [7:0] p, input logic c);
    pad_in     = p;
    change_clr = c;
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] exp_gpio,
                             input logic [7:0] exp_changed, input logic exp_ev);
`ifndef GPIO_F2M_EVENT_EN
    exp_changed = 8'h00;
    exp_ev      = 1'b0;
`endif
    total++;
    if (gpio !== exp_gpio) begin
      bad++;
      $display("[TB] FAIL %s gpio got=%h want=%h", tag, gpio, exp_gpio);
    end
    total++;
    if (changed !== exp_changed) begin
      bad++;
      $display("[TB] FAIL %s changed got=%h want=%h", tag, changed, exp_changed);
    end
    total++;
    if (event_out !== exp_ev) begin
      bad++;
      $display("[TB] FAIL %s event got=%b want=%b", tag, event_out, exp_ev);
    end
  endtask

  initial begin
    total      = 0;
    bad        = 0;
    rst_n      = 1'b0;
    pad_in     = 8'h00;
    change_clr = 1'b0;

    // Clean step on channel 0: output follows on the 6th sampling edge.
    for (int i = 0; i < 5; i++) add_row(8'h01, 1'b0, 8'h00, 8'h00, 1'b0);
    add_row(8'h01, 1'b0, 8'h01, 8'h01, 1'b1);
    add_row(8'h01, 1'b0, 8'h01, 8'h01, 1'b0);
    // Firmware clear, then release.
    add_row(8'h01, 1'b1, 8'h01, 8'h00, 1'b0);
    add_row(8'h01, 1'b0, 8'h01, 8'h00, 1'b0);
    // Falling step on channel 0.
    for (int i = 0; i < 5; i++) add_row(8'h00, 1'b0, 8'h01, 8'h00, 1'b0);
    add_row(8'h00, 1'b0, 8'h00, 8'h01, 1'b1);
    add_row(8'h00, 1'b0, 8'h00, 8'h01, 1'b0);
    add_row(8'h00, 1'b1, 8'h00, 8'h00, 1'b0);
    add_row(8'h00, 1'b0, 8'h00, 8'h00, 1'b0);
    // Four channels at once.
    for (int i = 0; i < 5; i++) add_row(8'hA5, 1'b0, 8'h00, 8'h00, 1'b0);
    add_row(8'hA5, 1'b0, 8'hA5, 8'hA5, 1'b1);
    add_row(8'hA5, 1'b0, 8'hA5, 8'hA5, 1'b0);
    // Channel 1 glitch of exactly 4 clocks passes, then returns low.
    for (int i = 0; i < 4; i++) add_row(8'hA7, 1'b0, 8'hA5, 8'hA5, 1'b0);
    add_row(8'hA5, 1'b0, 8'hA5, 8'hA5, 1'b0);
    add_row(8'hA5, 1'b0, 8'hA7, 8'hA7, 1'b1);
    for (int i = 0; i < 3; i++) add_row(8'hA5, 1'b0, 8'hA7, 8'hA7, 1'b0);
    add_row(8'hA5, 1'b0, 8'hA5, 8'hA7, 1'b1);
    add_row(8'hA5, 1'b0, 8'hA5, 8'hA7, 1'b0);
    // Channel 4 glitch of 3 clocks is rejected.
    for (int i = 0; i < 3; i++) add_row(8'hB5, 1'b0, 8'hA5, 8'hA7, 1'b0);
    for (int i = 0; i < 4; i++) add_row(8'hA5, 1'b0, 8'hA5, 8'hA7, 1'b0);
    // Clear flags, then channel 3 bounces high 3 / low 1 and is rejected.
    add_row(8'hA5, 1'b1, 8'hA5, 8'h00, 1'b0);
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 3; i++) add_row(8'hAD, 1'b0, 8'hA5, 8'h00, 1'b0);
      add_row(8'hA5, 1'b0, 8'hA5, 8'h00, 1'b0);
    end
    for (int i = 0; i < 4; i++) add_row(8'hA5, 1'b0, 8'hA5, 8'h00, 1'b0);

    #1;
    checkOutput("reset_initial", 8'h00, 8'h00, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].pad, vecs[i].clr);
      checkOutput($sformatf("row%0d", i), vecs[i].gpio, vecs[i].changed, vecs[i].ev);
    end

    // Reset in the middle of qualification discards the progress at once.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(8'hFF, 1'b0);
      checkOutput($sformatf("pre_reset%0d", i), 8'hA5, 8'h00, 1'b0);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset", 8'h00, 8'h00, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(8'hFF, 1'b0);
      checkOutput($sformatf("post_reset%0d", i), 8'h00, 8'h00, 1'b0);
    end
    applyStimulus(8'hFF, 1'b0);
    checkOutput("post_reset_update", 8'hFF, 8'hFF, 1'b1);
    applyStimulus(8'hFF, 1'b0);
    checkOutput("post_reset_hold", 8'hFF, 8'hFF, 1'b0);

    // Clear held high while channel 5 qualifies: set wins on the update edge.
    pad_in = 8'h00;
    rst_n  = 1'b0;
    #1;
    checkOutput("reset_again", 8'h00, 8'h00, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(8'h20, 1'b1);
      checkOutput($sformatf("setclr%0d", i), 8'h00, 8'h00, 1'b0);
    end
    applyStimulus(8'h20, 1'b1);
    checkOutput("setclr_update", 8'h20, 8'h20, 1'b1);
    applyStimulus(8'h20, 1'b1);
    checkOutput("setclr_cleared", 8'h20, 8'h00, 1'b0);
    applyStimulus(8'h20, 1'b0);
    checkOutput("setclr_idle", 8'h20, 8'h00, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
